// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin transaction scheduler in front of the
// simulation SPI master. It packs the winning requester's {cmd, addr, data}
// into one frame, pulses tx_enb, follows the frame through cs low/high,
// returns the captured response, and enforces an idle gap between frames.
// Optional watchdog enabled by defining the macro SPI_SCHED_TIMEOUT_EN.
module spi_txn_scheduler #(
    parameter int N_REQ          = 2,
    parameter int CMD_W          = 8,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int RSP_W          = 7,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int FRAME_W       = CMD_W + ADDR_W + DATA_W
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*CMD_W-1:0]  req_cmd,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_enb,
    output logic [FRAME_W-1:0]      i_frame,
    input  logic                    cs,
    input  logic [RSP_W-1:0]        o_frame,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_id,
    output logic [RSP_W-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_END,
        GAP
    } state_t;

    state_t             state_q;
    logic [1:0]         rrPtr_q;
    logic [1:0]         gnt_q;
    logic [FRAME_W-1:0] frame_q;
    logic               txEnb_q;
    logic               busy_q;
    logic               rspValid_q;
    logic [1:0]         rspId_q;
    logic [RSP_W-1:0]   rspData_q;
    logic [GAP_W-1:0]   gapCnt_q;

    logic [2*N_REQ-1:0] validRot;
    logic               gntFound_d;
    logic [1:0]         gntOff;
    logic [2:0]         gntSum;
    logic [2:0]         ptrSum;
    logic [1:0]         gnt_d;
    logic [1:0]         rrPtr_d;
    logic [FRAME_W-1:0] frame_d;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] toCnt_q;
    logic        rspErr_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

    // Rotate the request vector so the round-robin pointer lands on bit 0.
    assign validRot = {req_valid, req_valid} >> rrPtr_q;

    // Lowest set bit of the rotated vector is the offset of the winner from the pointer.
    always_comb begin
        gntFound_d = 1'b0;
        gntOff     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (validRot[i]) begin
                gntFound_d = 1'b1;
                gntOff     = 2'(i);
            end
        end
    end

    // Map the offset back to an absolute requester index and compute the pointer after it.
    always_comb begin
        gntSum = {1'b0, rrPtr_q} + {1'b0, gntOff};
        if (gntSum >= 3'(N_REQ)) begin
            gntSum = gntSum - 3'(N_REQ);
        end
        gnt_d  = gntSum[1:0];
        ptrSum = {1'b0, gnt_d} + 3'd1;
        if (ptrSum >= 3'(N_REQ)) begin
            ptrSum = '0;
        end
        rrPtr_d = ptrSum[1:0];
    end

    // Select the winner's fields and build the frame with the command at the MSB.
    always_comb begin
        frame_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_d == 2'(i)) begin
                frame_d = {req_cmd[i*CMD_W +: CMD_W],
                           req_addr[i*ADDR_W +: ADDR_W],
                           req_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    // Accept strobe only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && gntFound_d) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_d == 2'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            gnt_q      <= '0;
            frame_q    <= '0;
            txEnb_q    <= 1'b0;
            busy_q     <= 1'b0;
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
            rspData_q  <= '0;
            gapCnt_q   <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            toCnt_q    <= '0;
            rspErr_q   <= 1'b0;
`endif
        end else begin
            txEnb_q    <= 1'b0;
            rspValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gntFound_d) begin
                        frame_q <= frame_d;
                        gnt_q   <= gnt_d;
                        rrPtr_q <= rrPtr_d;
                        txEnb_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                    toCnt_q <= '0;
`endif
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (!cs) begin
                        state_q <= WAIT_END;
`ifdef SPI_SCHED_TIMEOUT_EN
                        toCnt_q <= toCnt_q + 16'd1;
                    end else if (toCnt_q >= TO_LAST) begin
                        rspValid_q <= 1'b1;
                        rspErr_q   <= 1'b1;
                        rspData_q  <= '0;
                        rspId_q    <= gnt_q;
                        gapCnt_q   <= GAP_LOAD;
                        state_q    <= GAP;
                    end else begin
                        toCnt_q <= toCnt_q + 16'd1;
`endif
                    end
                end
                WAIT_END: begin
                    if (cs) begin
                        rspValid_q <= 1'b1;
                        rspData_q  <= o_frame;
                        rspId_q    <= gnt_q;
                        gapCnt_q   <= GAP_LOAD;
                        state_q    <= GAP;
`ifdef SPI_SCHED_TIMEOUT_EN
                        rspErr_q   <= 1'b0;
                    end else if (toCnt_q >= TO_LAST) begin
                        rspValid_q <= 1'b1;
                        rspErr_q   <= 1'b1;
                        rspData_q  <= '0;
                        rspId_q    <= gnt_q;
                        gapCnt_q   <= GAP_LOAD;
                        state_q    <= GAP;
                    end else begin
                        toCnt_q <= toCnt_q + 16'd1;
`endif
                    end
                end
                GAP: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                    if (!cs) begin
                        gapCnt_q <= gapCnt_q;
                    end else
`endif
                    if (gapCnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_enb    = txEnb_q;
    assign i_frame   = frame_q;
    assign busy      = busy_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    assign rsp_err   = rspErr_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Testbench for spi_txn_scheduler: randomized requests against a round-robin
// reference model, plus directed single/contention/gap/reset/stability checks.
// The watchdog scenario runs when SPI_SCHED_TIMEOUT_EN is defined.
module tb_spi_txn_scheduler;

    localparam int N_REQ          = 2;
    localparam int CMD_W          = 8;
    localparam int ADDR_W         = 8;
    localparam int DATA_W         = 8;
    localparam int RSP_W          = 7;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int FRAME_W        = CMD_W + ADDR_W + DATA_W;

    logic                    sysclk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*CMD_W-1:0]  req_cmd;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_enb;
    logic [FRAME_W-1:0]      i_frame;
    logic                    cs;
    logic [RSP_W-1:0]        o_frame;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [RSP_W-1:0]        rsp_data;
    logic                    rsp_err;
    logic                    busy;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCount  = 0;
    int rrModel     = 0;

    spi_txn_scheduler #(
        .N_REQ(N_REQ), .CMD_W(CMD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RSP_W(RSP_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .tx_enb(tx_enb), .i_frame(i_frame),
        .cs(cs), .o_frame(o_frame), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    // Free-running cycle counter for latency measurements.
    always @(posedge sysclk) cycleCount++;

    // Hard stop in case the bench itself wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got hang, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Reference arbiter: first valid index at or after the pointer, wrapping.
    function automatic int modelPick(input logic [N_REQ-1:0] valid, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (valid[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [FRAME_W-1:0] expFrame(input int idx);
        return {req_cmd[idx*CMD_W +: CMD_W], req_addr[idx*ADDR_W +: ADDR_W],
                req_data[idx*DATA_W +: DATA_W]};
    endfunction

    task automatic applyStimulus(input int idx, input logic [7:0] c, input logic [7:0] a,
                                 input logic [7:0] d);
        req_cmd[idx*CMD_W +: CMD_W]    = c;
        req_addr[idx*ADDR_W +: ADDR_W] = a;
        req_data[idx*DATA_W +: DATA_W] = d;
        req_valid[idx]                 = 1'b1;
    endtask

    task automatic randomFields();
        for (int i = 0; i < N_REQ; i++) begin
            req_cmd[i*CMD_W +: CMD_W]    = CMD_W'($urandom());
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
            req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom());
        end
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge sysclk);
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Plays the SPI master for one frame and reports what the scheduler did.
    task automatic doTransaction(input logic [RSP_W-1:0] rspVal, input bit dropValid,
                                 output bit sawLaunch, output logic [FRAME_W-1:0] launchFrame,
                                 output int launchCycle, output int csRiseCycle,
                                 output bit sawRsp, output logic [1:0] gotId,
                                 output logic [RSP_W-1:0] gotData, output logic gotErr);
        sawLaunch = 1'b0; sawRsp = 1'b0; launchFrame = '0; launchCycle = 0;
        csRiseCycle = 0; gotId = '0; gotData = '0; gotErr = 1'b0;
        for (int i = 0; i < 40 && !sawLaunch; i++) begin
            @(negedge sysclk);
            if (tx_enb === 1'b1) begin
                sawLaunch   = 1'b1;
                launchFrame = i_frame;
                launchCycle = cycleCount;
            end
        end
        if (!sawLaunch) return;
        if (dropValid) req_valid = '0;
        repeat ($urandom_range(1, 3)) @(negedge sysclk);
        cs = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge sysclk);
        o_frame     = rspVal;
        cs          = 1'b1;
        csRiseCycle = cycleCount;
        for (int i = 0; i < 6 && !sawRsp; i++) begin
            @(negedge sysclk);
            if (rsp_valid === 1'b1) begin
                sawRsp  = 1'b1;
                gotId   = rsp_id;
                gotData = rsp_data;
                gotErr  = rsp_err;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; cs = 1'b1; o_frame = '0; req_valid = '1;
        randomFields();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b, expected 0", req_ready); end
        vectors++; if (tx_enb !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_enb: got %b, expected 0", tx_enb); end
        vectors++; if (i_frame !== '0) begin miscompares++; $display("[TB] FAIL reset_i_frame: got %h, expected 0", i_frame); end
        vectors++; if ({rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp_busy: got %b, expected 0", {rsp_valid, rsp_id, rsp_data, rsp_err, busy}); end
        repeat (3) @(negedge sysclk);
        req_valid = '0; rst_n = 1'b1; rrModel = 0;
        @(negedge sysclk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_contention();
        bit sl, sr, ok; logic [FRAME_W-1:0] fr; int lc, cr; logic [1:0] id; logic [RSP_W-1:0] d, r; logic e; int exp;
        randomFields();
        req_valid = '1;
        for (int t = 0; t < 4; t++) begin
            exp = modelPick(req_valid, rrModel);
            r = RSP_W'($urandom());
            doTransaction(r, 1'b0, sl, fr, lc, cr, sr, id, d, e);
            vectors++; if (sl !== 1'b1 || fr !== expFrame(exp)) begin miscompares++; $display("[TB] FAIL contention_frame: got %h, expected %h", fr, expFrame(exp)); end
            vectors++; if (sr !== 1'b1 || id !== 2'(exp) || d !== r) begin miscompares++; $display("[TB] FAIL contention_rsp: got id %0d data %h, expected id %0d data %h", id, d, exp, r); end
            rrModel = (exp + 1) % N_REQ;
        end
        req_valid = '0;
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL contention_idle: got busy, expected idle"); end
    endtask

    task automatic test_single();
        bit sl, sr, ok; logic [FRAME_W-1:0] fr; int lc, cr, acc; logic [1:0] id; logic [RSP_W-1:0] d; logic e;
        applyStimulus(0, 8'h01, 8'h10, 8'h7F);
        #1;
        acc = cycleCount;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL single_req_ready: got %b, expected 01", req_ready); end
        doTransaction(7'h55, 1'b1, sl, fr, lc, cr, sr, id, d, e);
        vectors++; if (sl !== 1'b1 || lc !== acc + 1) begin miscompares++; $display("[TB] FAIL single_launch_cycle: got %0d, expected %0d", lc, acc + 1); end
        vectors++; if (fr !== 24'h01107F) begin miscompares++; $display("[TB] FAIL single_frame: got %h, expected 01107f", fr); end
        vectors++; if (sr !== 1'b1 || id !== 2'd0 || d !== 7'h55 || e !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rsp: got id %0d data %h err %b, expected id 0 data 55 err 0", id, d, e); end
        @(negedge sysclk);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rsp_pulse: got %b, expected 0", rsp_valid); end
        rrModel = 1 % N_REQ;
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_idle: got busy, expected idle"); end
    endtask

    task automatic test_gap();
        bit sl, sr, ok; logic [FRAME_W-1:0] fr; int lc, cr, cr1, exp; logic [1:0] id; logic [RSP_W-1:0] d, r; logic e;
        randomFields();
        req_valid = 2'b10;
        cr1 = 0;
        for (int t = 0; t < 2; t++) begin
            exp = modelPick(req_valid, rrModel);
            r = RSP_W'($urandom());
            doTransaction(r, 1'b0, sl, fr, lc, cr, sr, id, d, e);
            vectors++; if (sl !== 1'b1 || sr !== 1'b1 || id !== 2'(exp) || d !== r) begin miscompares++; $display("[TB] FAIL gap_rsp: got id %0d data %h, expected id %0d data %h", id, d, exp, r); end
            if (t == 1) begin
                vectors++; if (lc - cr1 < GAP_CYCLES + 1) begin miscompares++; $display("[TB] FAIL gap_cycles: got %0d, expected >= %0d", lc - cr1, GAP_CYCLES + 1); end
            end
            cr1 = cr;
            rrModel = (exp + 1) % N_REQ;
        end
        req_valid = '0;
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_idle: got busy, expected idle"); end
    endtask

    task automatic test_random();
        bit sl, sr, ok; logic [FRAME_W-1:0] fr, ef; int lc, cr, exp; logic [1:0] id; logic [RSP_W-1:0] d, r; logic e;
        for (int t = 0; t < 10; t++) begin
            randomFields();
            req_valid = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            exp = modelPick(req_valid, rrModel);
            ef  = expFrame(exp);
            r   = RSP_W'($urandom());
            doTransaction(r, 1'b1, sl, fr, lc, cr, sr, id, d, e);
            vectors++; if (sl !== 1'b1 || fr !== ef) begin miscompares++; $display("[TB] FAIL random_frame: got %h, expected %h", fr, ef); end
            vectors++; if (sr !== 1'b1 || id !== 2'(exp) || d !== r || e !== 1'b0) begin miscompares++; $display("[TB] FAIL random_rsp: got id %0d data %h err %b, expected id %0d data %h err 0", id, d, e, exp, r); end
            rrModel = (exp + 1) % N_REQ;
        end
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL random_idle: got busy, expected idle"); end
    endtask

    task automatic test_stable();
        bit sl, sr, ok; logic [FRAME_W-1:0] ef; int exp, other; logic [RSP_W-1:0] r;
        randomFields();
        req_valid = '1;
        exp   = modelPick(req_valid, rrModel);
        other = (exp + 1) % N_REQ;
        ef    = expFrame(exp);
        sl = 1'b0;
        for (int i = 0; i < 40 && !sl; i++) begin
            @(negedge sysclk);
            if (tx_enb === 1'b1) sl = 1'b1;
        end
        vectors++; if (sl !== 1'b1 || i_frame !== ef) begin miscompares++; $display("[TB] FAIL stable_launch: got %h, expected %h", i_frame, ef); end
        rrModel = (exp + 1) % N_REQ;
        req_valid[exp] = 1'b0;
        @(negedge sysclk); cs = 1'b0;
        repeat (2) @(negedge sysclk);
        req_data[other*DATA_W +: DATA_W] = ~req_data[other*DATA_W +: DATA_W];
        @(negedge sysclk);
        vectors++; if (i_frame !== ef) begin miscompares++; $display("[TB] FAIL stable_frame_wait_end: got %h, expected %h", i_frame, ef); end
        r = RSP_W'($urandom());
        o_frame = r; cs = 1'b1;
        sr = 1'b0;
        for (int i = 0; i < 6 && !sr; i++) begin
            @(negedge sysclk);
            if (rsp_valid === 1'b1) begin
                sr = 1'b1;
                vectors++; if (rsp_id !== 2'(exp) || rsp_data !== r) begin miscompares++; $display("[TB] FAIL stable_rsp: got id %0d data %h, expected id %0d data %h", rsp_id, rsp_data, exp, r); end
            end
        end
        req_valid = '0;
        vectors++; if (sr !== 1'b1 || i_frame !== ef) begin miscompares++; $display("[TB] FAIL stable_after_rsp: got rsp %b frame %h, expected rsp 1 frame %h", sr, i_frame, ef); end
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL stable_idle: got busy, expected idle"); end
    endtask

    task automatic test_reset_midframe();
        bit sl, sr, ok; logic [FRAME_W-1:0] fr; int lc, cr, exp; logic [1:0] id; logic [RSP_W-1:0] d, r; logic e;
        randomFields();
        req_valid = 2'b01;
        sl = 1'b0;
        for (int i = 0; i < 40 && !sl; i++) begin
            @(negedge sysclk);
            if (tx_enb === 1'b1) sl = 1'b1;
        end
        vectors++; if (sl !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_launch: got none, expected tx_enb"); end
        req_valid = '0;
        @(negedge sysclk); cs = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b0; req_valid = '1;
        #1;
        vectors++; if ({tx_enb, i_frame, rsp_valid, rsp_id, rsp_data, rsp_err, busy, req_ready} !== '0) begin miscompares++; $display("[TB] FAIL midreset_outputs: got %h, expected 0", {tx_enb, i_frame, rsp_valid, rsp_id, rsp_data, rsp_err, busy, req_ready}); end
        cs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_no_rsp: got %b, expected 0", rsp_valid); end
        end
        rrModel = 0;
        rst_n = 1'b1;
        exp = modelPick(req_valid, rrModel);
        r = RSP_W'($urandom());
        doTransaction(r, 1'b1, sl, fr, lc, cr, sr, id, d, e);
        vectors++; if (sl !== 1'b1 || fr !== expFrame(exp) || sr !== 1'b1 || id !== 2'(exp) || d !== r) begin miscompares++; $display("[TB] FAIL midreset_regrant: got id %0d frame %h, expected id %0d frame %h", id, fr, exp, expFrame(exp)); end
        rrModel = (exp + 1) % N_REQ;
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_idle: got busy, expected idle"); end
    endtask

`ifdef SPI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit sl, sr, ok; int lc, exp;
        randomFields();
        req_valid = 2'b01;
        exp = modelPick(req_valid, rrModel);
        sl = 1'b0; lc = 0;
        for (int i = 0; i < 40 && !sl; i++) begin
            @(negedge sysclk);
            if (tx_enb === 1'b1) begin sl = 1'b1; lc = cycleCount; end
        end
        req_valid = '0;
        rrModel = (exp + 1) % N_REQ;
        sr = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES + 20 && !sr; i++) begin
            @(negedge sysclk);
            if (rsp_valid === 1'b1) begin
                sr = 1'b1;
                vectors++; if (cycleCount - lc !== TIMEOUT_CYCLES + 1) begin miscompares++; $display("[TB] FAIL timeout_latency: got %0d, expected %0d", cycleCount - lc, TIMEOUT_CYCLES + 1); end
                vectors++; if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'(exp)) begin miscompares++; $display("[TB] FAIL timeout_rsp: got err %b data %h id %0d, expected err 1 data 0 id %0d", rsp_err, rsp_data, rsp_id, exp); end
            end
        end
        vectors++; if (sl !== 1'b1 || sr !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_seen: got launch %b rsp %b, expected 1 1", sl, sr); end
        waitIdle(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_idle: got busy, expected idle"); end
    endtask
`endif

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_contention();
        test_single();
        test_gap();
        test_random();
        test_stable();
        test_reset_midframe();
`ifdef SPI_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
